boot_bus_sequencer: RTL and testbench
=====================================

Name: boot_bus_sequencer

Overview:
Owns the shared 16-bit address bus and the RAM/EEPROM chip selects from power-up onward.
- Boot: holds the CPU in reset, resets and runs the EEPROM-to-RAM copier, and muxes the copier onto the bus until it reports done.
- After boot: hands the bus to the CPU, then arbitrates it between the CPU and a DMA requester with a req/gnt handshake and a bounded DMA hold time.

Parameters:
COPIER_RESET_CYCLES, 4, cycles copier_reset_n held low after entering boot.
RELEASE_CYCLES, 2, idle bus cycles between copier done and CPU reset release.
DMA_MAX_CYCLES, 64, maximum consecutive cycles DMA may hold the bus.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
copier_reset_n  out  1  reset to boot copier
copier_done  in  1  copier finished, level
copier_address  in  16  copier address
copier_ram_we_n  in  1  copier RAM write strobe
cpu_reset_n  out  1  CPU reset
cpu_idle  in  1  CPU between bus cycles, safe to take bus
cpu_wait_n  out  1  low = CPU must stall, bus not owned
cpu_address  in  16  CPU address
cpu_ram_we_n  in  1  CPU RAM write strobe
cpu_ram_cs_n  in  1  CPU RAM select
dma_req  in  1  DMA bus request, level
dma_gnt  out  1  DMA owns bus
dma_address  in  16  DMA address
dma_ram_we_n  in  1  DMA RAM write strobe
address  out  16  shared address bus
ram_we_n  out  1  RAM write enable
ram_cs_n  out  1  RAM chip select
eeprom_oe_n  out  1  EEPROM output enable
eeprom_cs_n  out  1  EEPROM chip select
boot_done  out  1  high once CPU released

Behaviour:
- States: HOLD, COPY, SETTLE, CPU, DMA, COOL.
- Reset (async): state=HOLD, counter=0.
- Reset output values: copier_reset_n=0, cpu_reset_n=0, cpu_wait_n=0, dma_gnt=0, address=16'h0000, ram_we_n=1, ram_cs_n=1, eeprom_oe_n=1, eeprom_cs_n=1, boot_done=0.
- All outputs are registered, except the address/strobe mux, which is combinational from state.
- HOLD: copier_reset_n=0; count COPIER_RESET_CYCLES, then go to COPY with counter cleared.
- COPY: copier_reset_n=1; address=copier_address; ram_we_n=copier_ram_we_n; ram_cs_n=0, eeprom_cs_n=0, eeprom_oe_n=0. When copier_done=1, go to SETTLE.
- SETTLE: all selects/strobes inactive (1); address=16'hFFFF; copier_reset_n stays 1. After RELEASE_CYCLES, go to CPU and set cpu_reset_n=1, boot_done=1.
- boot_done and cpu_reset_n remain 1 until reset_n asserts. The EEPROM is never selected after COPY.
- CPU: bus = cpu_address, cpu_ram_we_n, cpu_ram_cs_n; cpu_wait_n=1.
  - If dma_req=1 and cpu_idle=1 on a rising edge: next state DMA, dma_gnt=1, cpu_wait_n=0, counter cleared.
  - If dma_req=1 and cpu_idle=0: stay in CPU, no grant.
- DMA: bus = dma_address, dma_ram_we_n; ram_cs_n=0; counter increments each cycle.
  - dma_req=0: next state CPU, dma_gnt=0, cpu_wait_n=1.
  - Counter reaches DMA_MAX_CYCLES-1 with req still high: dma_gnt=0, next state COOL.
- COOL: one cycle with CPU on the bus; cpu_wait_n=1; dma_req ignored. Then CPU. This guarantees the CPU at least one cycle between DMA bursts.
- Grant latency is 1 cycle from a sampled (dma_req & cpu_idle); release latency is 1 cycle from dma_req deassert.
- Boot phase: dma_req ignored in HOLD/COPY/SETTLE; dma_gnt stays 0. cpu_idle is don't-care.
- copier_done high on the first COPY cycle goes straight to SETTLE (zero-length copy allowed).
- Reset mid-operation (any state): immediate return to reset values. Copier and CPU are re-reset and the copy restarts.
- Unreachable state encodings go to HOLD.

Test Plan:
- Reset, copier_done raised on cycle 20 of COPY -> copier_reset_n low exactly 4 cycles; EEPROM/RAM selects low during COPY; address tracks copier_address (e.g. 16'hE123); selects high for 2 SETTLE cycles with address 16'hFFFF; then cpu_reset_n=1, boot_done=1.
- dma_req=1 during COPY -> dma_gnt stays 0 and copier keeps the bus; grant occurs only after boot_done, given cpu_idle=1.
- In CPU state, dma_req=1 with cpu_idle=0 for 5 cycles, then cpu_idle=1 -> dma_gnt=1 and cpu_wait_n=0 one cycle later; address switches to dma_address 16'h4000; dma_req drop -> grant 0 and wait_n 1 next cycle.
- dma_req held 100 cycles -> dma_gnt high exactly 64 cycles, then 1 COOL cycle with CPU on the bus, then re-grant when cpu_idle=1.
- reset_n pulsed low while in DMA -> all outputs return to reset values asynchronously; the HOLD/COPY sequence repeats in full.
- copier_done already high on COPY entry -> COPY lasts 1 cycle, then SETTLE proceeds normally.

Source files
------------

// File: rtl/boot_bus_sequencer_if.sv
// Shared boot/CPU/DMA bus bundle.
// master = sequencer, slave = copier/CPU/DMA/memory side.
interface boot_bus_sequencer_if;
    logic        copier_reset_n;
    logic        copier_done;
    logic [15:0] copier_address;
    logic        copier_ram_we_n;
    logic        cpu_reset_n;
    logic        cpu_idle;
    logic        cpu_wait_n;
    logic [15:0] cpu_address;
    logic        cpu_ram_we_n;
    logic        cpu_ram_cs_n;
    logic        dma_req;
    logic        dma_gnt;
    logic [15:0] dma_address;
    logic        dma_ram_we_n;
    logic [15:0] address;
    logic        ram_we_n;
    logic        ram_cs_n;
    logic        eeprom_oe_n;
    logic        eeprom_cs_n;
    logic        boot_done;

    modport master (
        output copier_reset_n,
        input  copier_done,
        input  copier_address,
        input  copier_ram_we_n,
        output cpu_reset_n,
        input  cpu_idle,
        output cpu_wait_n,
        input  cpu_address,
        input  cpu_ram_we_n,
        input  cpu_ram_cs_n,
        input  dma_req,
        output dma_gnt,
        input  dma_address,
        input  dma_ram_we_n,
        output address,
        output ram_we_n,
        output ram_cs_n,
        output eeprom_oe_n,
        output eeprom_cs_n,
        output boot_done
    );

    modport slave (
        input  copier_reset_n,
        output copier_done,
        output copier_address,
        output copier_ram_we_n,
        input  cpu_reset_n,
        output cpu_idle,
        input  cpu_wait_n,
        output cpu_address,
        output cpu_ram_we_n,
        output cpu_ram_cs_n,
        output dma_req,
        input  dma_gnt,
        output dma_address,
        output dma_ram_we_n,
        input  address,
        input  ram_we_n,
        input  ram_cs_n,
        input  eeprom_oe_n,
        input  eeprom_cs_n,
        input  boot_done
    );
endinterface

// File: rtl/boot_bus_sequencer.sv
// Boot bus owner: copier boot, CPU release, then CPU/DMA arbitration.
// Control outputs are registered; the address/strobe mux decodes state.
module boot_bus_sequencer #(
    parameter int unsigned COPIER_RESET_CYCLES = 4,
    parameter int unsigned RELEASE_CYCLES      = 2,
    parameter int unsigned DMA_MAX_CYCLES      = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    boot_bus_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        COPY   = 3'd1,
        SETTLE = 3'd2,
        CPU    = 3'd3,
        DMA    = 3'd4,
        COOL   = 3'd5
    } state_e;

    localparam logic [15:0] HOLD_LAST   = 16'(COPIER_RESET_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(RELEASE_CYCLES - 1);
    localparam logic [15:0] DMA_LAST    = 16'(DMA_MAX_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic copier_reset_n_q;
    logic cpu_reset_n_q;
    logic cpu_wait_n_q;
    logic dma_gnt_q;
    logic boot_done_q;

    logic [15:0] address_mux;
    logic        ram_we_mux;
    logic        ram_cs_mux;
    logic        eeprom_oe_mux;
    logic        eeprom_cs_mux;

    // Next-state and cycle counter for boot timing and DMA hold limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = COPY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COPY: begin
                if (bus.copier_done) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CPU;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CPU: begin
                if (bus.dma_req && bus.cpu_idle) begin
                    state_d = DMA;
                    cnt_d   = '0;
                end
            end
            DMA: begin
                if (!bus.dma_req) begin
                    state_d = CPU;
                    cnt_d   = '0;
                end else if (cnt_q == DMA_LAST) begin
                    state_d = COOL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COOL: begin
                state_d = CPU;
                cnt_d   = '0;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered control outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= HOLD;
            cnt_q            <= '0;
            copier_reset_n_q <= 1'b0;
            cpu_reset_n_q    <= 1'b0;
            cpu_wait_n_q     <= 1'b0;
            dma_gnt_q        <= 1'b0;
            boot_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            copier_reset_n_q <= (state_d != HOLD);
            cpu_reset_n_q    <= (state_d == CPU) || (state_d == DMA)
                                || (state_d == COOL);
            boot_done_q      <= (state_d == CPU) || (state_d == DMA)
                                || (state_d == COOL);
            cpu_wait_n_q     <= (state_d == CPU) || (state_d == COOL);
            dma_gnt_q        <= (state_d == DMA);
        end
    end

    // Bus owner mux; SETTLE parks the address high with all strobes off.
    always_comb begin
        address_mux   = 16'h0000;
        ram_we_mux    = 1'b1;
        ram_cs_mux    = 1'b1;
        eeprom_oe_mux = 1'b1;
        eeprom_cs_mux = 1'b1;
        case (state_q)
            COPY: begin
                address_mux   = bus.copier_address;
                ram_we_mux    = bus.copier_ram_we_n;
                ram_cs_mux    = 1'b0;
                eeprom_oe_mux = 1'b0;
                eeprom_cs_mux = 1'b0;
            end
            SETTLE: begin
                address_mux = 16'hFFFF;
            end
            CPU, COOL: begin
                address_mux = bus.cpu_address;
                ram_we_mux  = bus.cpu_ram_we_n;
                ram_cs_mux  = bus.cpu_ram_cs_n;
            end
            DMA: begin
                address_mux = bus.dma_address;
                ram_we_mux  = bus.dma_ram_we_n;
                ram_cs_mux  = 1'b0;
            end
            default: begin
                address_mux = 16'h0000;
            end
        endcase
    end

    assign bus.copier_reset_n = copier_reset_n_q;
    assign bus.cpu_reset_n    = cpu_reset_n_q;
    assign bus.cpu_wait_n     = cpu_wait_n_q;
    assign bus.dma_gnt        = dma_gnt_q;
    assign bus.boot_done      = boot_done_q;
    assign bus.address        = address_mux;
    assign bus.ram_we_n       = ram_we_mux;
    assign bus.ram_cs_n       = ram_cs_mux;
    assign bus.eeprom_oe_n    = eeprom_oe_mux;
    assign bus.eeprom_cs_n    = eeprom_cs_mux;

endmodule

// File: tb/tb_boot_bus_sequencer.sv
// Directed bench for boot_bus_sequencer.
// Control bits: {cr, cpur, wait, gnt, we, cs, oe, ecs, done}.
module tb_boot_bus_sequencer;

    logic clock;
    logic reset_n;
    int   passed;
    int   total;

    boot_bus_sequencer_if bus ();

    boot_bus_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    wire [8:0] ctrl = {bus.copier_reset_n, bus.cpu_reset_n,
                       bus.cpu_wait_n, bus.dma_gnt, bus.ram_we_n,
                       bus.ram_cs_n, bus.eeprom_oe_n, bus.eeprom_cs_n,
                       bus.boot_done};

    localparam logic [8:0] V_RST    = 9'b000011110;
    localparam logic [8:0] V_COPY   = 9'b100000000;
    localparam logic [8:0] V_SETTLE = 9'b100011110;
    localparam logic [8:0] V_CPU    = 9'b111010111;
    localparam logic [8:0] V_DMA    = 9'b110100111;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic count_hold(input string name);
        int n;
        n = 0;
        while (bus.copier_reset_n === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== 4)
            $display("FAIL %s: copier reset low %0d cycles, want 4",
                     name, n);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if (ctrl !== V_RST)
            $display("FAIL reset_ctrl: got %b want %b", ctrl, V_RST);
        else passed++;
        total++;
        if (bus.address !== 16'h0000)
            $display("FAIL reset_addr: got %h want 0000", bus.address);
        else passed++;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (ctrl !== V_RST)
            $display("FAIL reset_held: got %b want %b", ctrl, V_RST);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        count_hold("hold_len");
    endtask

    task automatic test_boot_copy();
        logic [15:0] exp_addr;
        bus.dma_req  = 1'b1;
        bus.cpu_idle = 1'b1;
        exp_addr = 16'hE123;
        for (int i = 1; i <= 20; i++) begin
            if (i == 10) begin
                bus.copier_address = 16'h0ABC;
                exp_addr = 16'h0ABC;
                #1;
            end
            total++;
            if (ctrl !== V_COPY || bus.address !== exp_addr)
                $display("FAIL copy_c%0d: got %b/%h want %b/%h",
                         i, ctrl, bus.address, V_COPY, exp_addr);
            else passed++;
            if (i < 20) tick();
        end
        bus.copier_done = 1'b1;
        tick();
        bus.copier_done = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            total++;
            if (ctrl !== V_SETTLE || bus.address !== 16'hFFFF)
                $display("FAIL settle_c%0d: got %b/%h want %b/ffff",
                         i, ctrl, bus.address, V_SETTLE);
            else passed++;
            tick();
        end
        total++;
        if (ctrl !== V_CPU || bus.address !== 16'h1234)
            $display("FAIL boot_cpu: got %b/%h want %b/1234",
                     ctrl, bus.address, V_CPU);
        else passed++;
        tick();
        total++;
        if (ctrl !== V_DMA || bus.address !== 16'h4000)
            $display("FAIL boot_first_gnt: got %b/%h want %b/4000",
                     ctrl, bus.address, V_DMA);
        else passed++;
        bus.dma_req = 1'b0;
        tick();
        total++;
        if (ctrl !== V_CPU)
            $display("FAIL boot_release: got %b want %b", ctrl, V_CPU);
        else passed++;
    endtask

    task automatic test_dma_grant();
        bus.dma_req  = 1'b1;
        bus.cpu_idle = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (ctrl !== V_CPU || bus.address !== 16'h1234)
                $display("FAIL busy_c%0d: got %b/%h want %b/1234",
                         i, ctrl, bus.address, V_CPU);
            else passed++;
        end
        bus.cpu_idle = 1'b1;
        tick();
        total++;
        if (ctrl !== V_DMA || bus.address !== 16'h4000)
            $display("FAIL grant: got %b/%h want %b/4000",
                     ctrl, bus.address, V_DMA);
        else passed++;
        bus.dma_req = 1'b0;
        tick();
        total++;
        if (ctrl !== V_CPU || bus.address !== 16'h1234)
            $display("FAIL release: got %b/%h want %b/1234",
                     ctrl, bus.address, V_CPU);
        else passed++;
    endtask

    task automatic test_dma_max();
        logic g [1:100];
        int   run;
        bus.dma_req  = 1'b1;
        bus.cpu_idle = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            g[i] = bus.dma_gnt;
            if (i == 65) begin
                total++;
                if (ctrl !== V_CPU || bus.address !== 16'h1234)
                    $display("FAIL cool: got %b/%h want %b/1234",
                             ctrl, bus.address, V_CPU);
                else passed++;
            end
        end
        run = 0;
        while (run < 100 && g[run + 1] === 1'b1) run++;
        total++;
        if (run !== 64)
            $display("FAIL dma_max: gnt held %0d cycles, want 64", run);
        else passed++;
        total++;
        if ({g[65], g[66], g[67]} !== 3'b001)
            $display("FAIL regrant: got %b want 001",
                     {g[65], g[66], g[67]});
        else passed++;
        bus.dma_req = 1'b0;
        tick();
        total++;
        if (ctrl !== V_CPU)
            $display("FAIL max_release: got %b want %b", ctrl, V_CPU);
        else passed++;
    endtask

    task automatic test_reset_mid_dma();
        bus.dma_req  = 1'b1;
        bus.cpu_idle = 1'b1;
        tick();
        total++;
        if (ctrl !== V_DMA)
            $display("FAIL pre_reset_dma: got %b want %b", ctrl, V_DMA);
        else passed++;
        reset_n = 1'b0;
        #2;
        total++;
        if (ctrl !== V_RST || bus.address !== 16'h0000)
            $display("FAIL async_reset: got %b/%h want %b/0000",
                     ctrl, bus.address, V_RST);
        else passed++;
        @(negedge clock);
        bus.copier_done = 1'b1;
        reset_n = 1'b1;
        count_hold("rehold_len");
    endtask

    task automatic test_zero_copy();
        total++;
        if (ctrl !== V_COPY || bus.address !== 16'h0ABC)
            $display("FAIL zcopy: got %b/%h want %b/0abc",
                     ctrl, bus.address, V_COPY);
        else passed++;
        tick();
        for (int i = 1; i <= 2; i++) begin
            total++;
            if (ctrl !== V_SETTLE || bus.address !== 16'hFFFF)
                $display("FAIL zsettle_c%0d: got %b/%h want %b/ffff",
                         i, ctrl, bus.address, V_SETTLE);
            else passed++;
            tick();
        end
        total++;
        if (ctrl !== V_CPU)
            $display("FAIL zcpu: got %b want %b", ctrl, V_CPU);
        else passed++;
        bus.dma_req = 1'b0;
        tick();
        total++;
        if (ctrl !== V_CPU)
            $display("FAIL zcpu_hold: got %b want %b", ctrl, V_CPU);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset_n             = 1'b0;
        bus.copier_done     = 1'b0;
        bus.copier_address  = 16'hE123;
        bus.copier_ram_we_n = 1'b0;
        bus.cpu_idle        = 1'b0;
        bus.cpu_address     = 16'h1234;
        bus.cpu_ram_we_n    = 1'b1;
        bus.cpu_ram_cs_n    = 1'b0;
        bus.dma_req         = 1'b0;
        bus.dma_address     = 16'h4000;
        bus.dma_ram_we_n    = 1'b0;
        test_reset();
        test_boot_copy();
        test_dma_grant();
        test_dma_max();
        test_reset_mid_dma();
        test_zero_copy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
